// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: state, select and condition-code encodings shared by the ARM multi-cycle controller
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE;

    // The never code (4'hF) falls through to false
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            CC_EQ:   cond_eval = z;
            CC_NE:   cond_eval = !z;
            CC_CS:   cond_eval = c;
            CC_CC:   cond_eval = !c;
            CC_MI:   cond_eval = n;
            CC_PL:   cond_eval = !n;
            CC_VS:   cond_eval = v;
            CC_VC:   cond_eval = !v;
            CC_HI:   cond_eval = c && !z;
            CC_LS:   cond_eval = !c || z;
            CC_GE:   cond_eval = n == v;
            CC_LT:   cond_eval = n != v;
            CC_GT:   cond_eval = !z && n == v;
            CC_LE:   cond_eval = z || n != v;
            CC_AL:   cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_condlogic.sv
// arm_condlogic: NZCV flag register with split N/Z and C/V write enables, plus condition evaluation
module arm_condlogic
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] flag_we,
    output logic       CondEx
);

    logic [3:0] flags_q, flags_d;

    // flag_we[1] loads N,Z; flag_we[0] loads C,V
    always_comb begin
        flags_d[3:2] = flag_we[1] ? ALUFlags[3:2] : flags_q[3:2];
        flags_d[1:0] = flag_we[0] ? ALUFlags[1:0] : flags_q[1:0];
    end

    // Flag register, cleared while in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    assign CondEx = cond_eval(cond, flags_q);

endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multi-cycle ARM control FSM with shared memory port; ARM_PERF_CNT_EN adds cycle/instruction counters
module arm_mc_controller
    import arm_ctrl_pkg::*;
`ifdef ARM_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0]      Instr,
    input  logic [3:0]       ALUFlags,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       RegSrc,
    output logic [1:0]       ImmSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ResultSrc,
    output logic             BrL,
`ifdef ARM_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
`endif
    output logic             illegal
);

    state_e     state_q, state_d;
    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic [2:0] alu_op;
    logic       cmd_ok, is_cmp, cv_cmd, nz_we, cond_ex;
    logic       unused_instr;

    assign cond         = Instr[19:16];
    assign op           = Instr[15:14];
    assign funct        = Instr[13:8];
    assign cmd          = funct[4:1];
    assign unused_instr = ^Instr[7:0];
    assign ImmSrc       = op;

    assign is_cmp = cmd == CMD_CMP;
    assign cv_cmd = cmd == CMD_ADD || cmd == CMD_SUB || is_cmp;
    assign nz_we  = (state_q == S_EXECUTER || state_q == S_EXECUTEI) && funct[0];

    arm_condlogic u_condlogic (
        .clk      (clk),
        .reset    (reset),
        .cond     (cond),
        .ALUFlags (ALUFlags),
        .flag_we  ({nz_we, nz_we && cv_cmd}),
        .CondEx   (cond_ex)
    );

    // ALU command decode; unknown commands fall back to ADD and are flagged
    always_comb begin
        alu_op = ALU_ADD;
        cmd_ok = 1'b1;
        case (cmd)
            CMD_ADD:          alu_op = ALU_ADD;
            CMD_SUB, CMD_CMP: alu_op = ALU_SUB;
            CMD_AND:          alu_op = ALU_AND;
            CMD_ORR:          alu_op = ALU_ORR;
            CMD_EOR:          alu_op = ALU_EOR;
            CMD_MOV:          alu_op = ALU_MOV;
            default:          cmd_ok = 1'b0;
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state and datapath controls; strobes are gated off while reset is held
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALUOUT;
        BrL        = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                illegal = cond_ex && op == 2'b11;
                state_d = !cond_ex       ? S_FETCH :
                          op == OP_MEM   ? S_MEMADR :
                          op == OP_DP    ? (funct[5] ? S_EXECUTEI : S_EXECUTER) :
                          op == OP_BR    ? S_BRANCH : S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                RegSrc  = 2'b10;
                state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = RES_READDATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                RegSrc   = 2'b10;
                state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = state_q == S_EXECUTEI ? SRCB_IMM : SRCB_REG;
                ALUControl = alu_op;
                illegal    = !cmd_ok;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = !is_cmp;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                RegSrc    = 2'b01;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
                RegWrite  = funct[4];
                BrL       = funct[4];
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (!reset) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

`ifdef ARM_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instr_q;

    // Free-running cycle count and count of completed instruction fetches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            instr_q <= instr_q + CNT_W'(state_q == S_FETCH && mem_ready);
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: per-instruction transaction checks of arm_mc_controller against an instruction-level model
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, BrL, illegal;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic [2:0]  ALUControl;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  mflags = '0;

    typedef struct packed {
        int         cyc;
        int         req;
        int         mw;
        int         mw_ok;
        int         rw;
        int         pcw;
        int         ir;
        int         br_ok;
        int         brl;
        int         ill;
        int         imm_bad;
        logic [1:0] rsrc;
        logic [1:0] srcb;
        logic [2:0] alu;
    } tally_t;

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .BrL        (BrL),
        .illegal    (illegal)
    );

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level expectations: latency, strobe counts and flag effect of one instruction
    task automatic model(input logic [19:0] ins, input int fw, input int mw, input logic [3:0] af, output tally_t e);
        logic [1:0] op;
        logic [5:0] fn;
        bit legal, cmp, arith;
        logic [2:0] alu;
        op = ins[15:14];
        fn = ins[13:8];
        e = '0;
        e.cyc = 2 + fw;
        e.req = 1 + fw;
        e.pcw = 1;
        e.ir  = 1;
        if (!cond_ok(ins[19:16], mflags)) return;
        if (op == 2'b11) begin
            e.ill = 1;
        end else if (op == 2'b00) begin
            legal = 1; cmp = 0; arith = 0; alu = 3'd0;
            case (fn[4:1])
                4'b0100: begin alu = 3'd0; arith = 1; end
                4'b0010: begin alu = 3'd1; arith = 1; end
                4'b1010: begin alu = 3'd1; arith = 1; cmp = 1; end
                4'b0000: alu = 3'd2;
                4'b1100: alu = 3'd3;
                4'b0001: alu = 3'd4;
                4'b1101: alu = 3'd5;
                default: legal = 0;
            endcase
            e.cyc  = e.cyc + 2;
            e.alu  = alu;
            e.srcb = fn[5] ? 2'b01 : 2'b00;
            e.rw   = cmp ? 0 : 1;
            e.ill  = legal ? 0 : 1;
            if (fn[0]) begin
                mflags[3:2] = af[3:2];
                if (arith) mflags[1:0] = af[1:0];
            end
        end else if (op == 2'b01) begin
            e.srcb = 2'b01;
            e.req  = e.req + 1 + mw;
            if (fn[0]) begin
                e.cyc  = e.cyc + 3 + mw;
                e.rw   = 1;
                e.rsrc = 2'b01;
            end else begin
                e.cyc   = e.cyc + 2 + mw;
                e.mw    = 1 + mw;
                e.mw_ok = 1 + mw;
            end
        end else begin
            e.cyc   = e.cyc + 1;
            e.srcb  = 2'b01;
            e.pcw   = 2;
            e.br_ok = 1;
            e.rw    = fn[4] ? 1 : 0;
            e.brl   = fn[4] ? 1 : 0;
            e.rsrc  = fn[4] ? 2'b10 : 2'b00;
        end
    endtask

    // Runs one instruction from its FETCH to the next FETCH, acting as a memory with fw/mw wait cycles
    task automatic run_instr(input logic [19:0] ins, input int fw, input int mw, input logic [3:0] af, output tally_t o);
        int fc, mc;
        bit seen_ir, done;
        o = '0; fc = 0; mc = 0; seen_ir = 0; done = 0;
        while (!done && o.cyc < 64) begin
            Instr = ins;
            ALUFlags = af;
            if (mem_req && !AdrSrc) begin
                mem_ready = (fc == fw);
                fc++;
            end else if (mem_req) begin
                mem_ready = (mc == mw);
                mc++;
            end else begin
                mem_ready = 1'($urandom);
            end
            @(negedge clk);
            if (mem_req) o.req++;
            if (MemWrite) o.mw++;
            if (MemWrite && mem_req && AdrSrc && RegSrc == 2'b10) o.mw_ok++;
            if (RegWrite) begin
                o.rw++;
                o.rsrc = ResultSrc;
            end
            if (PCWrite) o.pcw++;
            if (IRWrite && PCWrite) begin
                o.ir++;
                seen_ir = 1;
            end
            if (PCWrite && !IRWrite && RegSrc[0] && !ALUSrcA) o.br_ok++;
            if (BrL) o.brl++;
            if (illegal) o.ill++;
            if (ImmSrc !== ins[15:14]) o.imm_bad++;
            if (o.cyc == fw + 2) begin
                o.alu  = ALUControl;
                o.srcb = ALUSrcB;
            end
            o.cyc++;
            @(posedge clk);
            #1;
            done = seen_ir && mem_req && !AdrSrc;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        Instr = 20'hE5954;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: strobes=%b expected 000000", {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, AdrSrc, MemWrite} !== 3'b110) begin
            errors++;
            $display("FAIL memread_entry: {mem_req,AdrSrc,MemWrite}=%b expected 110", {mem_req, AdrSrc, MemWrite});
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_access: strobes=%b expected 000000", {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, AdrSrc, IRWrite, RegWrite} !== 4'b1000) begin
            errors++;
            $display("FAIL post_reset_fetch: {mem_req,AdrSrc,IRWrite,RegWrite}=%b expected 1000", {mem_req, AdrSrc, IRWrite, RegWrite});
        end
        @(posedge clk);
        #1;
        mflags = '0;
    endtask

    task automatic test_dp;
        tally_t o, e;
        logic [19:0] seq [3];
        seq = '{20'hE0821, 20'h0A000, 20'hE1A00};
        for (int i = 0; i < 3; i++) begin
            model(seq[i], 0, 0, 4'b1111, e);
            run_instr(seq[i], 0, 0, 4'b1111, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL dp[%0d] instr=%h: got %p expected %p", i, seq[i], o, e);
            end
        end
        model(20'hE0821, 0, 0, 4'b0000, e);
        run_instr(20'hE0821, 0, 0, 4'b0000, o);
        checks++;
        if (o.cyc !== 4 || o.rw !== 1 || o.rsrc !== 2'b00 || o.alu !== 3'b000 || o.srcb !== 2'b00) begin
            errors++;
            $display("FAIL add_direct: cyc=%0d rw=%0d rsrc=%b alu=%b srcb=%b expected 4 1 00 000 00", o.cyc, o.rw, o.rsrc, o.alu, o.srcb);
        end
    endtask

    task automatic test_flags;
        tally_t o, e;
        logic [19:0] seq [4];
        logic [3:0] afs [4];
        seq = '{20'hE2500, 20'h0A000, 20'hE2500, 20'h0A000};
        afs = '{4'b0100, 4'b0000, 4'b0000, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            model(seq[i], 0, 0, afs[i], e);
            run_instr(seq[i], 0, 0, afs[i], o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL flags[%0d] instr=%h: got %p expected %p", i, seq[i], o, e);
            end
            if (i == 1) begin
                checks++;
                if (o.br_ok !== 1 || o.cyc !== 3) begin
                    errors++;
                    $display("FAIL beq_taken: br_ok=%0d cyc=%0d expected 1 3", o.br_ok, o.cyc);
                end
            end
            if (i == 3) begin
                checks++;
                if (o.pcw !== 1 || o.rw !== 0 || o.cyc !== 2) begin
                    errors++;
                    $display("FAIL beq_skipped: pcw=%0d rw=%0d cyc=%0d expected 1 0 2", o.pcw, o.rw, o.cyc);
                end
            end
        end
    endtask

    task automatic test_mem;
        tally_t o, e;
        model(20'hE5954, 0, 2, 4'b0000, e);
        run_instr(20'hE5954, 0, 2, 4'b0000, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL ldr_wait2: got %p expected %p", o, e);
        end
        checks++;
        if (o.cyc !== 7 || o.req !== 4 || o.rw !== 1 || o.rsrc !== 2'b01) begin
            errors++;
            $display("FAIL ldr_direct: cyc=%0d req=%0d rw=%0d rsrc=%b expected 7 4 1 01", o.cyc, o.req, o.rw, o.rsrc);
        end
        model(20'hE5854, 1, 3, 4'b0000, e);
        run_instr(20'hE5854, 1, 3, 4'b0000, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL str_wait3: got %p expected %p", o, e);
        end
        checks++;
        if (o.mw !== 4 || o.mw_ok !== 4 || o.rw !== 0 || o.cyc !== 8) begin
            errors++;
            $display("FAIL str_direct: mw=%0d mw_ok=%0d rw=%0d cyc=%0d expected 4 4 0 8", o.mw, o.mw_ok, o.rw, o.cyc);
        end
    endtask

    task automatic test_branch;
        tally_t o, e;
        model(20'hEB000, 0, 0, 4'b0000, e);
        run_instr(20'hEB000, 0, 0, 4'b0000, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL bl: got %p expected %p", o, e);
        end
        checks++;
        if (o.br_ok !== 1 || o.brl !== 1 || o.rw !== 1 || o.rsrc !== 2'b10 || o.cyc !== 3) begin
            errors++;
            $display("FAIL bl_direct: br_ok=%0d brl=%0d rw=%0d rsrc=%b cyc=%0d expected 1 1 1 10 3", o.br_ok, o.brl, o.rw, o.rsrc, o.cyc);
        end
        model(20'hEC000, 0, 0, 4'b0000, e);
        run_instr(20'hEC000, 0, 0, 4'b0000, o);
        checks++;
        if (o.ill !== 1 || o.cyc !== 2 || o !== e) begin
            errors++;
            $display("FAIL illegal_op: got %p expected %p", o, e);
        end
    endtask

    task automatic test_random;
        tally_t o, e;
        logic [19:0] ins;
        logic [3:0] af;
        int fw, mw;
        for (int i = 0; i < 400; i++) begin
            ins = 20'($urandom);
            if ($urandom_range(1, 0) == 1) ins[19:16] = 4'hE;
            if ($urandom_range(3, 0) != 0 && ins[15:14] == 2'b11) ins[15:14] = 2'b00;
            fw = $urandom_range(2, 0);
            mw = $urandom_range(3, 0);
            af = 4'($urandom);
            model(ins, fw, mw, af, e);
            run_instr(ins, fw, mw, af, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random[%0d] instr=%h fw=%0d mw=%0d: got %p expected %p", i, ins, fw, mw, o, e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_dp;
        test_flags;
        test_mem;
        test_branch;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
